// File: rtl/riscv_pkg.sv
// Shared RV64I(+Zba) decode types: opcodes, ALU op codes, immediate formats, ID/EX payload.
// Also holds the immediate-extension helper used by the decode stage.
package riscv_pkg;

    localparam int XLEN   = 64;
    localparam int NREGS  = 32;
    localparam int REG_AW = 5;

    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_OP32    = 7'b0111011;

    typedef enum logic [4:0] {
        ALU_ADD       = 5'd0,
        ALU_SUB       = 5'd1,
        ALU_SLL       = 5'd2,
        ALU_SLT       = 5'd3,
        ALU_SLTU      = 5'd4,
        ALU_XOR       = 5'd5,
        ALU_SRL       = 5'd6,
        ALU_SRA       = 5'd7,
        ALU_OR        = 5'd8,
        ALU_AND       = 5'd9,
        ALU_LUI       = 5'd10,
        ALU_SH1ADD    = 5'd11,
        ALU_SH2ADD    = 5'd12,
        ALU_SH3ADD    = 5'd13,
        ALU_ADD_UW    = 5'd14,
        ALU_SH1ADD_UW = 5'd15,
        ALU_SH2ADD_UW = 5'd16,
        ALU_SH3ADD_UW = 5'd17,
        ALU_SLLI_UW   = 5'd18
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_src_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    typedef struct packed {
        logic [XLEN-1:0]   rd1;
        logic [XLEN-1:0]   rd2;
        logic [XLEN-1:0]   imm;
        logic [XLEN-1:0]   pc;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic              reg_write;
        logic              mem_write;
        logic              branch;
        logic              jump;
        logic              jump_reg;
        logic              alu_src_a;
        logic              alu_src;
        logic              word;
        logic              illegal;
        result_src_e       result_src;
        alu_op_e           alu_ctrl;
        logic [2:0]        funct3;
    } id_ex_t;

    function automatic logic [XLEN-1:0] imm_ext(input logic [31:0] i, input imm_src_e src);
        case (src)
            IMM_S:   return {{52{i[31]}}, i[31:25], i[11:7]};
            IMM_B:   return {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            IMM_U:   return {{32{i[31]}}, i[31:12], 12'b0};
            IMM_J:   return {{43{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: return {{52{i[31]}}, i[31:20]};
        endcase
    endfunction

endpackage

// File: rtl/register_file.sv
// Integer register file, 2 read / 1 write, x0 hardwired to zero, cleared on reset.
// Latency: reads combinational with write-first bypass; write lands on the rising edge.
// Backpressure: none; the write port is accepted every cycle.
module register_file
    import riscv_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [XLEN-1:0]   wdata,
    input  logic [REG_AW-1:0] raddr1,
    input  logic [REG_AW-1:0] raddr2,
    output logic [XLEN-1:0]   rdata1,
    output logic [XLEN-1:0]   rdata2
);

    logic [XLEN-1:0] regs [NREGS];
    logic            wr_ok;

    assign wr_ok = we && (waddr != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NREGS; k++) begin
                regs[k] <= '0;
            end
        end else if (wr_ok) begin
            regs[waddr] <= wdata;
        end
    end

    // x0 is never written, so it reads back zero without a special case
    assign rdata1 = (wr_ok && waddr == raddr1) ? wdata : regs[raddr1];
    assign rdata2 = (wr_ok && waddr == raddr2) ? wdata : regs[raddr2];

endmodule

// File: rtl/decode.sv
// RV64I decode stage: control + immediates + register read, registered into ID/EX.
// Latency: 1 cycle D->E. Zba decoding enabled by defining RV_ZBA_EN.
// Backpressure: none; ID/EX loads every edge, Flush_E loads a zero bubble.
module decode
    import riscv_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              Flush_E,
    input  logic [XLEN-1:0]   PC_D,
    input  logic [31:0]       Instr_D,
    input  logic              RegWrite_W,
    input  logic [REG_AW-1:0] Rd_W,
    input  logic [XLEN-1:0]   Result_W,
    output logic [REG_AW-1:0] Rs1_D,
    output logic [REG_AW-1:0] Rs2_D,
    output logic [XLEN-1:0]   RD1_E,
    output logic [XLEN-1:0]   RD2_E,
    output logic [XLEN-1:0]   ImmExt_E,
    output logic [XLEN-1:0]   PC_E,
    output logic [REG_AW-1:0] Rs1_E,
    output logic [REG_AW-1:0] Rs2_E,
    output logic [REG_AW-1:0] Rd_E,
    output logic              RegWrite_E,
    output logic              MemWrite_E,
    output logic              Branch_E,
    output logic              Jump_E,
    output logic              JumpReg_E,
    output logic              ALUSrcA_E,
    output logic              ALUSrc_E,
    output logic              Word_E,
    output logic              Illegal_E,
    output logic [1:0]        ResultSrc_E,
    output logic [4:0]        ALUControl_E,
    output logic [2:0]        Funct3_E
);

    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [5:0]      f6;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    imm_src_e        imm_src;
    id_ex_t          id_ex_d;
    id_ex_t          id_ex_q;

    assign opcode = Instr_D[6:0];
    assign f3     = Instr_D[14:12];
    assign f7     = Instr_D[31:25];
    assign f6     = Instr_D[31:26];
    assign Rs1_D  = Instr_D[19:15];
    assign Rs2_D  = Instr_D[24:20];

    register_file u_regfile (
        .clk    (clk),
        .rst    (rst),
        .we     (RegWrite_W),
        .waddr  (Rd_W),
        .wdata  (Result_W),
        .raddr1 (Rs1_D),
        .raddr2 (Rs2_D),
        .rdata1 (rd1),
        .rdata2 (rd2)
    );

    always_comb begin
        id_ex_d        = '0;
        imm_src        = IMM_I;
        id_ex_d.pc     = PC_D;
        id_ex_d.rs1    = Rs1_D;
        id_ex_d.rs2    = Rs2_D;
        id_ex_d.rd     = Instr_D[11:7];
        id_ex_d.funct3 = f3;
        id_ex_d.rd1    = rd1;
        id_ex_d.rd2    = rd2;

        case (opcode)
            OPC_LUI: begin
                id_ex_d.reg_write = 1'b1;
                id_ex_d.alu_src   = 1'b1;
                id_ex_d.alu_ctrl  = ALU_LUI;
                imm_src           = IMM_U;
            end
            OPC_AUIPC: begin
                id_ex_d.reg_write = 1'b1;
                id_ex_d.alu_src_a = 1'b1;
                id_ex_d.alu_src   = 1'b1;
                imm_src           = IMM_U;
            end
            OPC_JAL: begin
                id_ex_d.reg_write  = 1'b1;
                id_ex_d.jump       = 1'b1;
                id_ex_d.result_src = RES_PC4;
                imm_src            = IMM_J;
            end
            OPC_JALR: begin
                id_ex_d.reg_write  = 1'b1;
                id_ex_d.jump       = 1'b1;
                id_ex_d.jump_reg   = 1'b1;
                id_ex_d.alu_src    = 1'b1;
                id_ex_d.result_src = RES_PC4;
                id_ex_d.illegal    = (f3 != 3'b000);
            end
            OPC_BRANCH: begin
                id_ex_d.branch   = 1'b1;
                id_ex_d.alu_ctrl = ALU_SUB;
                imm_src          = IMM_B;
                id_ex_d.illegal  = (f3 == 3'b010) || (f3 == 3'b011);
            end
            OPC_LOAD: begin
                id_ex_d.reg_write  = 1'b1;
                id_ex_d.alu_src    = 1'b1;
                id_ex_d.result_src = RES_MEM;
                id_ex_d.illegal    = (f3 == 3'b111);
            end
            OPC_STORE: begin
                id_ex_d.mem_write = 1'b1;
                id_ex_d.alu_src   = 1'b1;
                imm_src           = IMM_S;
                id_ex_d.illegal   = f3[2];
            end
            OPC_OP_IMM: begin
                id_ex_d.reg_write = 1'b1;
                id_ex_d.alu_src   = 1'b1;
                // RV64 shifts: instr[25] is shamt[5], so only [31:26] is funct
                case (f3)
                    3'b000: id_ex_d.alu_ctrl = ALU_ADD;
                    3'b010: id_ex_d.alu_ctrl = ALU_SLT;
                    3'b011: id_ex_d.alu_ctrl = ALU_SLTU;
                    3'b100: id_ex_d.alu_ctrl = ALU_XOR;
                    3'b110: id_ex_d.alu_ctrl = ALU_OR;
                    3'b111: id_ex_d.alu_ctrl = ALU_AND;
                    3'b001: begin
                        if (f6 == 6'b000000) id_ex_d.alu_ctrl = ALU_SLL;
                        else                 id_ex_d.illegal  = 1'b1;
                    end
                    default: begin
                        if (f6 == 6'b000000)      id_ex_d.alu_ctrl = ALU_SRL;
                        else if (f6 == 6'b010000) id_ex_d.alu_ctrl = ALU_SRA;
                        else                      id_ex_d.illegal  = 1'b1;
                    end
                endcase
            end
            OPC_OP: begin
                id_ex_d.reg_write = 1'b1;
                if (f7 == 7'b0000000) begin
                    case (f3)
                        3'b000:  id_ex_d.alu_ctrl = ALU_ADD;
                        3'b001:  id_ex_d.alu_ctrl = ALU_SLL;
                        3'b010:  id_ex_d.alu_ctrl = ALU_SLT;
                        3'b011:  id_ex_d.alu_ctrl = ALU_SLTU;
                        3'b100:  id_ex_d.alu_ctrl = ALU_XOR;
                        3'b101:  id_ex_d.alu_ctrl = ALU_SRL;
                        3'b110:  id_ex_d.alu_ctrl = ALU_OR;
                        default: id_ex_d.alu_ctrl = ALU_AND;
                    endcase
                end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
                    id_ex_d.alu_ctrl = ALU_SUB;
                end else if (f7 == 7'b0100000 && f3 == 3'b101) begin
                    id_ex_d.alu_ctrl = ALU_SRA;
`ifdef RV_ZBA_EN
                end else if (f7 == 7'b0010000 && f3 == 3'b010) begin
                    id_ex_d.alu_ctrl = ALU_SH1ADD;
                end else if (f7 == 7'b0010000 && f3 == 3'b100) begin
                    id_ex_d.alu_ctrl = ALU_SH2ADD;
                end else if (f7 == 7'b0010000 && f3 == 3'b110) begin
                    id_ex_d.alu_ctrl = ALU_SH3ADD;
`endif
                end else begin
                    id_ex_d.illegal = 1'b1;
                end
            end
            OPC_OP_IMM32: begin
                id_ex_d.reg_write = 1'b1;
                id_ex_d.alu_src   = 1'b1;
                id_ex_d.word      = 1'b1;
                // *W shifts take a 5-bit shamt; a set instr[25] fails the f7 match
                if (f3 == 3'b000) begin
                    id_ex_d.alu_ctrl = ALU_ADD;
                end else if (f3 == 3'b001 && f7 == 7'b0000000) begin
                    id_ex_d.alu_ctrl = ALU_SLL;
                end else if (f3 == 3'b101 && f7 == 7'b0000000) begin
                    id_ex_d.alu_ctrl = ALU_SRL;
                end else if (f3 == 3'b101 && f7 == 7'b0100000) begin
                    id_ex_d.alu_ctrl = ALU_SRA;
`ifdef RV_ZBA_EN
                end else if (f3 == 3'b001 && f6 == 6'b000010) begin
                    id_ex_d.alu_ctrl = ALU_SLLI_UW;
                    id_ex_d.word     = 1'b0;
`endif
                end else begin
                    id_ex_d.illegal = 1'b1;
                end
            end
            OPC_OP32: begin
                id_ex_d.reg_write = 1'b1;
                id_ex_d.word      = 1'b1;
                if (f7 == 7'b0000000 && f3 == 3'b000) begin
                    id_ex_d.alu_ctrl = ALU_ADD;
                end else if (f7 == 7'b0000000 && f3 == 3'b001) begin
                    id_ex_d.alu_ctrl = ALU_SLL;
                end else if (f7 == 7'b0000000 && f3 == 3'b101) begin
                    id_ex_d.alu_ctrl = ALU_SRL;
                end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
                    id_ex_d.alu_ctrl = ALU_SUB;
                end else if (f7 == 7'b0100000 && f3 == 3'b101) begin
                    id_ex_d.alu_ctrl = ALU_SRA;
`ifdef RV_ZBA_EN
                end else if (f7 == 7'b0000100 && f3 == 3'b000) begin
                    id_ex_d.alu_ctrl = ALU_ADD_UW;
                    id_ex_d.word     = 1'b0;
                end else if (f7 == 7'b0010000 && f3 == 3'b010) begin
                    id_ex_d.alu_ctrl = ALU_SH1ADD_UW;
                    id_ex_d.word     = 1'b0;
                end else if (f7 == 7'b0010000 && f3 == 3'b100) begin
                    id_ex_d.alu_ctrl = ALU_SH2ADD_UW;
                    id_ex_d.word     = 1'b0;
                end else if (f7 == 7'b0010000 && f3 == 3'b110) begin
                    id_ex_d.alu_ctrl = ALU_SH3ADD_UW;
                    id_ex_d.word     = 1'b0;
`endif
                end else begin
                    id_ex_d.illegal = 1'b1;
                end
            end
            default: id_ex_d.illegal = 1'b1;
        endcase

        // an illegal instruction must not change architectural state downstream
        if (id_ex_d.illegal) begin
            id_ex_d.reg_write = 1'b0;
            id_ex_d.mem_write = 1'b0;
            id_ex_d.branch    = 1'b0;
            id_ex_d.jump      = 1'b0;
            id_ex_d.jump_reg  = 1'b0;
        end

        id_ex_d.imm = imm_ext(Instr_D, imm_src);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_ex_q <= '0;
        end else if (Flush_E) begin
            id_ex_q <= '0;
        end else begin
            id_ex_q <= id_ex_d;
        end
    end

    assign RD1_E        = id_ex_q.rd1;
    assign RD2_E        = id_ex_q.rd2;
    assign ImmExt_E     = id_ex_q.imm;
    assign PC_E         = id_ex_q.pc;
    assign Rs1_E        = id_ex_q.rs1;
    assign Rs2_E        = id_ex_q.rs2;
    assign Rd_E         = id_ex_q.rd;
    assign RegWrite_E   = id_ex_q.reg_write;
    assign MemWrite_E   = id_ex_q.mem_write;
    assign Branch_E     = id_ex_q.branch;
    assign Jump_E       = id_ex_q.jump;
    assign JumpReg_E    = id_ex_q.jump_reg;
    assign ALUSrcA_E    = id_ex_q.alu_src_a;
    assign ALUSrc_E     = id_ex_q.alu_src;
    assign Word_E       = id_ex_q.word;
    assign Illegal_E    = id_ex_q.illegal;
    assign ResultSrc_E  = id_ex_q.result_src;
    assign ALUControl_E = id_ex_q.alu_ctrl;
    assign Funct3_E     = id_ex_q.funct3;

endmodule

// File: tb/tb_decode.sv
// Directed bench for the decode stage; expected values are hand-computed encodings.
module tb_decode;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        Flush_E;
    logic [63:0] PC_D;
    logic [31:0] Instr_D;
    logic        RegWrite_W;
    logic [4:0]  Rd_W;
    logic [63:0] Result_W;
    logic [4:0]  Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E;
    logic [63:0] RD1_E, RD2_E, ImmExt_E, PC_E;
    logic        RegWrite_E, MemWrite_E, Branch_E, Jump_E, JumpReg_E;
    logic        ALUSrcA_E, ALUSrc_E, Word_E, Illegal_E;
    logic [1:0]  ResultSrc_E;
    logic [4:0]  ALUControl_E;
    logic [2:0]  Funct3_E;

    int n_checks = 0;
    int n_fail   = 0;

    decode dut (
        .clk(clk), .rst(rst), .Flush_E(Flush_E), .PC_D(PC_D), .Instr_D(Instr_D),
        .RegWrite_W(RegWrite_W), .Rd_W(Rd_W), .Result_W(Result_W),
        .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .RD1_E(RD1_E), .RD2_E(RD2_E),
        .ImmExt_E(ImmExt_E), .PC_E(PC_E), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E), .Rd_E(Rd_E),
        .RegWrite_E(RegWrite_E), .MemWrite_E(MemWrite_E), .Branch_E(Branch_E),
        .Jump_E(Jump_E), .JumpReg_E(JumpReg_E), .ALUSrcA_E(ALUSrcA_E),
        .ALUSrc_E(ALUSrc_E), .Word_E(Word_E), .Illegal_E(Illegal_E),
        .ResultSrc_E(ResultSrc_E), .ALUControl_E(ALUControl_E), .Funct3_E(Funct3_E)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; Flush_E = 1'b0; PC_D = 64'h100; Instr_D = 32'h00500093;
        RegWrite_W = 1'b0; Rd_W = 5'd0; Result_W = '0;
        step();
        n_checks++;
        if ({RegWrite_E, Rd_E, ImmExt_E, PC_E} !== 70'd0) begin
            n_fail++; $display("FAIL reset_outputs: got %h want 0", {RegWrite_E, Rd_E, ImmExt_E, PC_E});
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_addi();
        PC_D = 64'h100; Instr_D = 32'h00500093;
        step();
        n_checks++;
        if ({Rd_E, RegWrite_E, ALUSrc_E, Illegal_E} !== {5'd1, 1'b1, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL addi_ctrl: got rd=%0d rw=%b src=%b ill=%b", Rd_E, RegWrite_E, ALUSrc_E, Illegal_E);
        end
        n_checks++;
        if (ImmExt_E !== 64'd5 || PC_E !== 64'h100 || ALUControl_E !== ALU_ADD) begin
            n_fail++; $display("FAIL addi_imm: got imm=%h pc=%h alu=%0d want 5/100/0", ImmExt_E, PC_E, ALUControl_E);
        end
    endtask

    task automatic test_lui();
        Instr_D = 32'h800002B7;
        step();
        n_checks++;
        if (ImmExt_E !== 64'hFFFFFFFF80000000 || Rd_E !== 5'd5 || ResultSrc_E !== 2'b00) begin
            n_fail++; $display("FAIL lui: got imm=%h rd=%0d rs=%b", ImmExt_E, Rd_E, ResultSrc_E);
        end
    endtask

    task automatic test_regfile();
        Instr_D = 32'h00008113; RegWrite_W = 1'b1; Rd_W = 5'd1; Result_W = 64'h1234;
        step();
        n_checks++;
        if (RD1_E !== 64'h1234) begin
            n_fail++; $display("FAIL rf_bypass: got %h want 1234", RD1_E);
        end
        RegWrite_W = 1'b0;
        step();
        n_checks++;
        if (RD1_E !== 64'h1234) begin
            n_fail++; $display("FAIL rf_stored: got %h want 1234", RD1_E);
        end
        Instr_D = 32'h00000113; RegWrite_W = 1'b1; Rd_W = 5'd0; Result_W = 64'hFF;
        step();
        n_checks++;
        if (RD1_E !== 64'd0) begin
            n_fail++; $display("FAIL rf_x0_bypass: got %h want 0", RD1_E);
        end
        RegWrite_W = 1'b0;
        step();
        n_checks++;
        if (RD1_E !== 64'd0) begin
            n_fail++; $display("FAIL rf_x0_read: got %h want 0", RD1_E);
        end
    endtask

    task automatic test_flush();
        Instr_D = 32'h0020B423; RegWrite_W = 1'b1; Rd_W = 5'd2; Result_W = 64'hDEAD;
        step();
        n_checks++;
        if (MemWrite_E !== 1'b1 || RegWrite_E !== 1'b0 || ImmExt_E !== 64'd8 || RD2_E !== 64'hDEAD || Funct3_E !== 3'b011) begin
            n_fail++; $display("FAIL sd: got mw=%b rw=%b imm=%h rd2=%h f3=%b", MemWrite_E, RegWrite_E, ImmExt_E, RD2_E, Funct3_E);
        end
        Flush_E = 1'b1; Rd_W = 5'd3; Result_W = 64'hABC;
        step();
        n_checks++;
        if ({MemWrite_E, ImmExt_E, PC_E, RD2_E, Rs2_E, Rs1_E, Funct3_E} !== 206'd0) begin
            n_fail++; $display("FAIL flush_bubble: got mw=%b imm=%h pc=%h rd2=%h", MemWrite_E, ImmExt_E, PC_E, RD2_E);
        end
        Flush_E = 1'b0; RegWrite_W = 1'b0; Instr_D = 32'h00018213;
        step();
        n_checks++;
        if (RD1_E !== 64'hABC || Rd_E !== 5'd4) begin
            n_fail++; $display("FAIL flush_write: got rd1=%h rd=%0d want abc/4", RD1_E, Rd_E);
        end
    endtask

    task automatic test_zba();
        Instr_D = 32'h2020A1B3;
        #1;
        n_checks++;
        if (Rs1_D !== 5'd1 || Rs2_D !== 5'd2) begin
            n_fail++; $display("FAIL rs_comb: got rs1=%0d rs2=%0d want 1/2", Rs1_D, Rs2_D);
        end
        step();
        n_checks++;
`ifdef RV_ZBA_EN
        if (ALUControl_E !== ALU_SH1ADD || Illegal_E !== 1'b0 || RegWrite_E !== 1'b1 || Word_E !== 1'b0) begin
            n_fail++; $display("FAIL sh1add: got alu=%0d ill=%b rw=%b w=%b", ALUControl_E, Illegal_E, RegWrite_E, Word_E);
        end
`else
        if (Illegal_E !== 1'b1 || RegWrite_E !== 1'b0) begin
            n_fail++; $display("FAIL sh1add_illegal: got ill=%b rw=%b want 1/0", Illegal_E, RegWrite_E);
        end
`endif
    endtask

    task automatic test_misc();
        Instr_D = 32'h0200909B;  // slliw x1,x1,32: shamt[5] set
        step();
        n_checks++;
        if (Illegal_E !== 1'b1 || RegWrite_E !== 1'b0) begin
            n_fail++; $display("FAIL slliw_shamt5: got ill=%b rw=%b want 1/0", Illegal_E, RegWrite_E);
        end
        Instr_D = 32'h02009093;  // slli x1,x1,32
        step();
        n_checks++;
        if (Illegal_E !== 1'b0 || ALUControl_E !== ALU_SLL || ImmExt_E !== 64'd32 || Word_E !== 1'b0) begin
            n_fail++; $display("FAIL slli64: got ill=%b alu=%0d imm=%h w=%b", Illegal_E, ALUControl_E, ImmExt_E, Word_E);
        end
        Instr_D = 32'h003100BB;  // addw x1,x2,x3
        step();
        n_checks++;
        if (Word_E !== 1'b1 || ALUControl_E !== ALU_ADD || RegWrite_E !== 1'b1 || ALUSrc_E !== 1'b0) begin
            n_fail++; $display("FAIL addw: got w=%b alu=%0d rw=%b src=%b", Word_E, ALUControl_E, RegWrite_E, ALUSrc_E);
        end
        Instr_D = 32'hFE208EE3;  // beq x1,x2,-4
        step();
        n_checks++;
        if (ImmExt_E !== 64'hFFFFFFFFFFFFFFFC || Branch_E !== 1'b1 || RegWrite_E !== 1'b0 || ALUControl_E !== ALU_SUB) begin
            n_fail++; $display("FAIL beq: got imm=%h br=%b rw=%b alu=%0d", ImmExt_E, Branch_E, RegWrite_E, ALUControl_E);
        end
        Instr_D = 32'h008000EF;  // jal x1,8
        step();
        n_checks++;
        if (ImmExt_E !== 64'd8 || Jump_E !== 1'b1 || ResultSrc_E !== 2'b10 || JumpReg_E !== 1'b0) begin
            n_fail++; $display("FAIL jal: got imm=%h j=%b rs=%b jr=%b", ImmExt_E, Jump_E, ResultSrc_E, JumpReg_E);
        end
        Instr_D = 32'h0000007F;  // unknown opcode
        step();
        n_checks++;
        if (Illegal_E !== 1'b1 || RegWrite_E !== 1'b0 || Jump_E !== 1'b0 || MemWrite_E !== 1'b0) begin
            n_fail++; $display("FAIL unknown_op: got ill=%b rw=%b j=%b mw=%b", Illegal_E, RegWrite_E, Jump_E, MemWrite_E);
        end
        Instr_D = 32'h00001517;  // auipc x10,1
        step();
        n_checks++;
        if (ALUSrcA_E !== 1'b1 || ImmExt_E !== 64'h1000 || Rd_E !== 5'd10) begin
            n_fail++; $display("FAIL auipc: got srca=%b imm=%h rd=%0d", ALUSrcA_E, ImmExt_E, Rd_E);
        end
    endtask

    task automatic test_reset_mid();
        Instr_D = 32'h00500093;
        step();
        #3 rst = 1'b0;
        #1;
        n_checks++;
        if (RegWrite_E !== 1'b0 || Rd_E !== 5'd0 || ImmExt_E !== 64'd0) begin
            n_fail++; $display("FAIL async_reset: got rw=%b rd=%0d imm=%h", RegWrite_E, Rd_E, ImmExt_E);
        end
        @(negedge clk);
        rst = 1'b1; Instr_D = 32'h00008113;
        step();
        n_checks++;
        if (RD1_E !== 64'd0 || Rd_E !== 5'd2) begin
            n_fail++; $display("FAIL reset_regfile: got rd1=%h rd=%0d want 0/2", RD1_E, Rd_E);
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_lui();
        test_regfile();
        test_flush();
        test_zba();
        test_misc();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
